// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the mac timestep sequencer.
package mac_ctrl_pkg;

  localparam int MAC_ADDR_W = 12;
  localparam logic [MAC_ADDR_W-1:0] IDLE_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_CLEAR,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    EM_IDLE,
    EM_HOLD,
    EM_GAP
  } emit_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spike_addr_fifo.sv
// Synchronous FIFO holding pending spike source addresses; head is readable combinationally.
module spike_addr_fifo #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          wr_data,
  output logic [ADDR_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (!do_push && do_pop) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mac_timestep_sequencer.sv
// Timestep sequencer for the spike-driven mac array: set phase, spike address streaming,
// drain, clear pulse and step-done handshake. Every output is a flop.
module mac_timestep_sequencer
  import mac_ctrl_pkg::*;
#(
  parameter int ADDR_W          = MAC_ADDR_W,
  parameter int FIFO_DEPTH      = 8,
  parameter int SET_CYCLES      = 4,
  parameter int HOLD_CYCLES     = 2,
  parameter int TIMESTEP_CYCLES = 256,
  parameter int CLEAR_CYCLES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              spike_valid,
  input  logic [ADDR_W-1:0] spike_addr,
  output logic              spike_ready,
  output logic              set_mac,
  output logic              clear_mac,
  output logic [ADDR_W-1:0] source_address,
  output logic              step_done,
  output logic [15:0]       timestep_count,
  output logic              busy
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PH_MAX = max3(SET_CYCLES, HOLD_CYCLES, CLEAR_CYCLES);
  localparam int PH_W   = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;
  localparam int TM_W   = $clog2(TIMESTEP_CYCLES);

  localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
  localparam logic [PH_W-1:0]   SET_LAST  = PH_W'(SET_CYCLES - 1);
  localparam logic [PH_W-1:0]   CLR_LAST  = PH_W'(CLEAR_CYCLES - 1);
  localparam logic [PH_W-1:0]   HOLD_LAST = PH_W'(HOLD_CYCLES - 1);
  localparam logic [TM_W-1:0]   TM_ONE    = TM_W'(1);
  localparam logic [TM_W-1:0]   TM_LAST   = TM_W'(TIMESTEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BUS_IDLE  = '1;

  state_t            state_q, state_d;
  emit_t             emit_q, emit_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [TM_W-1:0]   timer_q, timer_d;
  logic [15:0]       ts_count_q;
  logic [ADDR_W-1:0] src_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              emit_on, push, pop, fifo_flush;
  logic [ADDR_W-1:0] fifo_rd;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign timestep_count = ts_count_q;
  assign push           = spike_valid & spike_ready & (~fifo_full | pop);
  assign fifo_flush     = (state_d == S_INIT);

  spike_addr_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (fifo_flush),
    .push    (push),
    .pop     (pop),
    .wr_data (spike_addr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  if (phase_q == SET_LAST) state_d = S_RUN;
      S_RUN:   if (timer_q == TM_LAST) state_d = S_DRAIN;
      S_DRAIN: if (emit_q == EM_IDLE && fifo_empty) state_d = S_CLEAR;
      S_CLEAR: if (phase_q == CLR_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    if (start) state_d = S_INIT;
  end

  // Emitter: hold each popped address, then one parked gap cycle before the next pop.
  always_comb begin
    emit_on = (state_q == S_RUN || state_q == S_DRAIN) && !start;
    emit_d  = EM_IDLE;
    pop     = 1'b0;
    if (emit_on) begin
      case (emit_q)
        EM_HOLD: emit_d = (phase_q == HOLD_LAST) ? EM_GAP : EM_HOLD;
        default: begin
          if (!fifo_empty) begin
            pop    = 1'b1;
            emit_d = EM_HOLD;
          end
        end
      endcase
    end
  end

  always_comb begin
    phase_d = '0;
    if (!start && ((state_q == S_INIT  && state_d == S_INIT)  ||
                   (state_q == S_CLEAR && state_d == S_CLEAR) ||
                   (emit_q == EM_HOLD  && emit_d == EM_HOLD)))
      phase_d = phase_q + PH_ONE;

    timer_d = (state_q == S_RUN && state_d == S_RUN) ? timer_q + TM_ONE : '0;

    // Occupancy after this edge, so ready reflects the FIFO the upstream will see.
    cnt_d = fifo_count;
    if (fifo_flush) begin
      cnt_d = '0;
    end else begin
      if (push) cnt_d = cnt_d + CNT_ONE;
      if (pop)  cnt_d = cnt_d - CNT_ONE;
    end

    src_d = BUS_IDLE;
    if (emit_d == EM_HOLD) src_d = pop ? fifo_rd : source_address;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      emit_q         <= EM_IDLE;
      phase_q        <= '0;
      timer_q        <= '0;
      ts_count_q     <= '0;
      spike_ready    <= 1'b0;
      set_mac        <= 1'b0;
      clear_mac      <= 1'b0;
      step_done      <= 1'b0;
      busy           <= 1'b0;
      source_address <= BUS_IDLE;
    end else begin
      state_q        <= state_d;
      emit_q         <= emit_d;
      phase_q        <= phase_d;
      timer_q        <= timer_d;
      spike_ready    <= (state_d == S_RUN) && (cnt_d != CNT_FULL);
      set_mac        <= (state_d == S_INIT);
      clear_mac      <= (state_d == S_CLEAR);
      step_done      <= (state_d == S_DONE);
      busy           <= (state_d != S_IDLE);
      source_address <= src_d;
      if (state_d == S_DONE) ts_count_q <= ts_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_mac_timestep_sequencer.sv
// Randomised bench for mac_timestep_sequencer against a queue-based behavioural model.
module tb_mac_timestep_sequencer;
  import mac_ctrl_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 8;
  localparam int SETC  = 4;
  localparam int HOLDC = 2;
  localparam int TSC   = 256;
  localparam int CLRC  = 2;

  localparam int M_IDLE  = 0;
  localparam int M_INIT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;
  localparam int M_CLEAR = 4;
  localparam int M_DONE  = 5;

  logic          clk = 1'b0;
  logic          rst, start, spike_valid;
  logic [AW-1:0] spike_addr;
  logic          spike_ready, set_mac, clear_mac, step_done, busy;
  logic [AW-1:0] source_address;
  logic [15:0]   timestep_count;

  mac_timestep_sequencer #(
    .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .SET_CYCLES(SETC), .HOLD_CYCLES(HOLDC),
    .TIMESTEP_CYCLES(TSC), .CLEAR_CYCLES(CLRC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .spike_valid    (spike_valid),
    .spike_addr     (spike_addr),
    .spike_ready    (spike_ready),
    .set_mac        (set_mac),
    .clear_mac      (clear_mac),
    .source_address (source_address),
    .step_done      (step_done),
    .timestep_count (timestep_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phase countdowns, a queue for the FIFO and a hold/gap tracker.
  int            m_mode, m_left, m_run_left, m_hold;
  bit            m_gap;
  logic [AW-1:0] m_cur;
  logic [AW-1:0] m_q[$];
  logic [AW-1:0] up_q[$];
  logic [15:0]   m_count;

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_run_left = 0; m_hold = 0; m_gap = 0;
    m_cur = '0; m_q.delete(); m_count = 16'h0000;
  endtask

  function automatic bit model_ready();
    return (m_mode == M_RUN) && (m_q.size() < DEPTH);
  endfunction

  task automatic model_step(input bit st, input bit push, input logic [AW-1:0] a);
    bit em_idle, q_empty;
    if (st) begin
      m_mode = M_INIT; m_left = SETC; m_q.delete(); m_hold = 0; m_gap = 0;
      return;
    end
    em_idle = (m_hold == 0) && !m_gap;
    q_empty = (m_q.size() == 0);
    if (m_mode == M_RUN || m_mode == M_DRAIN) begin
      if (m_hold > 0) begin
        m_hold--;
        m_gap = (m_hold == 0);
      end else begin
        m_gap = 0;
        if (!q_empty) begin
          m_cur  = m_q.pop_front();
          m_hold = HOLDC;
        end
      end
    end
    if (push) m_q.push_back(a);
    case (m_mode)
      M_INIT:  begin m_left--; if (m_left == 0) begin m_mode = M_RUN; m_run_left = TSC; end end
      M_RUN:   begin m_run_left--; if (m_run_left == 0) m_mode = M_DRAIN; end
      M_DRAIN: if (em_idle && q_empty) begin m_mode = M_CLEAR; m_left = CLRC; end
      M_CLEAR: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_DONE; m_count = m_count + 16'd1; end
      end
      M_DONE:  begin m_mode = M_RUN; m_run_left = TSC; end
      default: ;
    endcase
  endtask

  task automatic compare_cycle();
    check("set_mac",        32'(set_mac),        32'(m_mode == M_INIT));
    check("clear_mac",      32'(clear_mac),      32'(m_mode == M_CLEAR));
    check("step_done",      32'(step_done),      32'(m_mode == M_DONE));
    check("busy",           32'(busy),           32'(m_mode != M_IDLE));
    check("spike_ready",    32'(spike_ready),    32'(model_ready()));
    check("source_address", 32'(source_address), 32'((m_hold > 0) ? m_cur : IDLE_ADDR));
    check("timestep_count", 32'(timestep_count), 32'(m_count));
    check("set_clear_excl", 32'(set_mac & clear_mac), 32'(0));
  endtask

  initial begin
    bit            st, acc, finished, aborted, restarted, forced, wrapped;
    bit            did_rst, pend_start, abort_chk;
    int            run_cyc, prev_mode, step_no;
    logic [15:0]   cnt_before;
    finished = 0; aborted = 0; restarted = 0; forced = 0; wrapped = 0;
    did_rst = 0; pend_start = 0; abort_chk = 0; step_no = 0; cnt_before = '0;

    rst = 1'b1; start = 1'b0; spike_valid = 1'b0; spike_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(spike_ready),    32'(0));
    check("rst_set",    32'(set_mac),        32'(0));
    check("rst_clear",  32'(clear_mac),      32'(0));
    check("rst_src",    32'(source_address), 32'(12'hFFF));
    check("rst_done",   32'(step_done),      32'(0));
    check("rst_count",  32'(timestep_count), 32'(0));
    check("rst_busy",   32'(busy),           32'(0));
    rst = 1'b0;
    model_reset();

    for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
      @(negedge clk);
      compare_cycle();
      rst = 1'b0;
      if (abort_chk) begin
        check("abort_set",   32'(set_mac),          32'(1));
        check("abort_src",   32'(source_address),   32'(12'hFFF));
        check("abort_fifo",  32'(dut.u_fifo.empty), 32'(1));
        check("abort_count", 32'(timestep_count),   32'(cnt_before));
        abort_chk = 0;
      end
      if (forced && !wrapped && m_mode == M_DONE) begin
        check("wrap_count", 32'(timestep_count), 32'(16'h0000));
        check("wrap_done",  32'(step_done),      32'(1));
        wrapped = 1;
      end

      st = 0;
      run_cyc = TSC - m_run_left;
      if (m_mode == M_IDLE && ((step_no == 0 && cyc == 3) || pend_start)) begin
        st = 1; pend_start = 0;
      end
      if (m_mode == M_RUN) begin
        case (step_no)
          1: if (run_cyc == 10) up_q.push_back(12'd13);
          2: if (run_cyc == 5) for (int k = 13; k <= 36; k++) up_q.push_back(AW'(k));
          3: begin
            if (run_cyc == 254) up_q.push_back(12'd14);
            if (run_cyc == 255) up_q.push_back(12'd15);
          end
          5: begin
            if (run_cyc == 20) up_q.push_back(12'd16);
            if (!aborted && m_hold == HOLDC && m_cur == 12'd16) begin
              st = 1; aborted = 1; abort_chk = 1; cnt_before = m_count;
            end
          end
          7: begin
            if ($urandom_range(0, 3) == 0) up_q.push_back(AW'($urandom_range(0, 12'hFFE)));
            if (run_cyc == 100 && !did_rst) begin
              rst = 1'b1; did_rst = 1; pend_start = 1;
              up_q.delete(); spike_valid = 1'b0; start = 1'b0;
              model_reset();
              continue;
            end
          end
          default: if ($urandom_range(0, 3) == 0) up_q.push_back(AW'($urandom_range(0, 12'hFFE)));
        endcase
      end
      if (aborted && !restarted && m_mode == M_INIT && m_left == 2) begin
        st = 1; restarted = 1;
      end
      if (step_no == 6 && m_mode == M_CLEAR && m_left == CLRC && !forced) begin
        force dut.ts_count_q = 16'hFFFF;
        #1;
        release dut.ts_count_q;
        m_count = 16'hFFFF;
        forced = 1;
      end

      spike_valid = (up_q.size() > 0);
      spike_addr  = spike_valid ? up_q[0] : '0;
      start       = st;
      acc = spike_valid && model_ready();
      if (acc) void'(up_q.pop_front());
      prev_mode = m_mode;
      model_step(st, acc, spike_addr);
      if (prev_mode != M_RUN && m_mode == M_RUN) step_no++;
      if (step_no == 8) finished = 1;
    end

    check("run_completed", 32'(finished), 32'(1));
    check("wrap_reached",  32'(wrapped),  32'(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
